// File: rtl/fdiv_arbiter.sv
// rtl/fdiv_arbiter.sv - two-requester round-robin arbiter in front of a shared fp divider
module fdiv_arbiter #(
  parameter int TIMEOUT = 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] dnd0,
  input  logic [31:0] der0,
  input  logic [31:0] dnd1,
  input  logic [31:0] der1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] quo,
  output logic        err,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_dnd,
  output logic [31:0] div_der,
  input  logic        div_done,
  input  logic [31:0] div_quo,
  input  logic        div_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          gnt;       // requester owning the operation in flight
  logic          prio;      // requester that wins when both are eligible
  logic          mask;      // set for the one IDLE cycle right after RESP
  logic [TW-1:0] timer;

  logic          elig0, elig1, any_req, pick, zero_der, timeout;
  logic [31:0]   pick_dnd, pick_der;

  // Eligibility, round-robin pick and the divide-by-zero bypass test
  always_comb begin
    elig0    = req0 && !(mask && !gnt);
    elig1    = req1 && !(mask && gnt);
    any_req  = elig0 || elig1;
    pick     = (elig0 && elig1) ? prio : elig1;
    pick_dnd = pick ? dnd1 : dnd0;
    pick_der = pick ? der1 : der0;
    zero_der = (pick_der[30:0] == 31'd0);
    timeout  = (timer == TW'(TIMEOUT - 1));
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    div_start = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE:  if (any_req) state_nx = zero_der ? RESP : ISSUE;
      ISSUE: begin
        div_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT:  if (div_done || timeout) state_nx = RESP;
      RESP:  begin
        ack0     = !gnt;
        ack1     = gnt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grant bookkeeping, operand latch, timer and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= 1'b0;
      prio    <= 1'b0;
      mask    <= 1'b0;
      timer   <= '0;
      quo     <= 32'd0;
      err     <= 1'b0;
      div_dnd <= 32'd0;
      div_der <= 32'd0;
    end else begin
      mask <= (state == RESP);
      case (state)
        IDLE: if (any_req) begin
          gnt     <= pick;
          div_dnd <= pick_dnd;
          div_der <= pick_der;
          if (zero_der) begin
            quo <= {pick_dnd[31] ^ pick_der[31], 8'hFF, 23'h0};
            err <= 1'b1;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          // a done arriving on the timeout cycle still delivers the real result
          if (div_done) begin
            quo <= div_quo;
            err <= div_err;
          end else if (timeout) begin
            quo <= 32'd0;
            err <= 1'b1;
          end
        end
        RESP: prio <= !gnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb/tb_fdiv_arbiter.sv - randomized self-checking bench for fdiv_arbiter
module tb_fdiv_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] dnd0 = '0, der0 = '0, dnd1 = '0, der1 = '0;
  logic        ack0, ack1, err, busy, div_start;
  logic [31:0] quo, div_dnd, div_der;
  logic        div_done, div_err;
  logic [31:0] div_quo;

  // divider model state
  logic        m_done = 1'b0;
  logic [31:0] m_quo = '0;
  logic        m_err = 1'b0;
  int          cnt = 0;
  int          div_delay = 5;    // 0 means the divider never answers
  logic [31:0] q_cfg = '0;
  logic        e_cfg = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] stray_q = '0;

  int n_checks = 0;
  int n_pass = 0;
  int last_served = 1;

  fdiv_arbiter #(.TIMEOUT(70)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .dnd0(dnd0), .der0(der0), .dnd1(dnd1), .der1(der1),
    .ack0(ack0), .ack1(ack1), .quo(quo), .err(err), .busy(busy),
    .div_start(div_start), .div_dnd(div_dnd), .div_der(div_der),
    .div_done(div_done), .div_quo(div_quo), .div_err(div_err)
  );

  always #5 clk = ~clk;

  assign div_done = m_done | stray;
  assign div_quo  = stray ? stray_q : m_quo;
  assign div_err  = stray ? 1'b1 : m_err;

  // Divider: answers div_delay cycles after sampling div_start; deliberately not reset
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (div_start && div_delay > 0) cnt <= div_delay;
    else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        m_done <= 1'b1;
        m_quo  <= q_cfg;
        m_err  <= e_cfg;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // {err, quo} the requester should receive
  function automatic logic [32:0] expect_res(input logic [31:0] dnd, input logic [31:0] der,
                                             input int dly, input logic [31:0] q, input logic e);
    if (der[30:0] == 31'd0) return {1'b1, dnd[31] ^ der[31], 8'hFF, 23'h0};
    if (dly == 0) return {1'b1, 32'h0};
    return {e, q};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_served = 1;
  endtask

  // One operation from an idle arbiter; operands in dnd*/der* are set by the caller
  task automatic op(input logic r0, input logic r1, input int dly,
                    output int req_to_ack, output int start_to_ack);
    int          win, who, sc;
    logic        saw_start, bypass;
    logic [31:0] s_dnd, s_der;
    logic [32:0] exp;
    div_delay = dly;
    q_cfg = $urandom;
    e_cfg = 1'($urandom_range(0, 1));
    win = (r0 && r1) ? 1 - last_served : (r1 ? 1 : 0);
    s_dnd = win ? dnd1 : dnd0;
    s_der = win ? der1 : der0;
    exp = expect_res(s_dnd, s_der, dly, q_cfg, e_cfg);
    bypass = (s_der[30:0] == 31'd0);
    req0 = r0;
    req1 = r1;
    who = -1; sc = 0; saw_start = 1'b0; req_to_ack = -1; start_to_ack = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (div_start) begin
        saw_start = 1'b1;
        sc = i;
        dnd0 = $urandom; der0 = $urandom; dnd1 = $urandom; der1 = $urandom;
      end
      if (ack0 || ack1) begin
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        req_to_ack = i;
        start_to_ack = i - sc;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("op_winner", 32'(who), 32'(win));
    check("op_quo", quo, exp[31:0]);
    check("op_err", 32'(err), 32'(exp[32]));
    check("op_start_seen", 32'(saw_start), 32'(!bypass));
    if (!bypass) begin
      check("op_div_dnd", div_dnd, s_dnd);
      check("op_div_der", div_der, s_der);
    end
    @(negedge clk);
    check("op_ack_width", 32'(ack0 | ack1), 32'd0);
    last_served = win;
    @(negedge clk);
  endtask

  initial begin
    int rta, sta, nack, who, seq[$];
    logic prev_ack, got_ack, got_busy, prev_e;
    logic [31:0] prev_q;

    // reset state
    @(negedge clk);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(div_start), 0);
    check("rst_err", 32'(err), 0);
    check("rst_quo", quo, 0);
    check("rst_div_dnd", div_dnd, 0);
    check("rst_div_der", div_der, 0);

    // contention: both held from the first cycle after reset
    do_reset();
    div_delay = 4;
    dnd0 = 32'h3F800000; der0 = 32'h40000000;
    dnd1 = 32'h40800000; der1 = 32'h40000000;
    req0 = 1'b1; req1 = 1'b1;
    nack = 0; prev_ack = 1'b0;
    for (int i = 0; i < 200 && nack < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check("cont_ack_width", 32'(prev_ack), 0);
        seq.push_back(ack1 ? 1 : 0);
        nack++;
      end
      prev_ack = ack0 | ack1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("cont_count", 32'(nack), 4);
    for (int k = 0; k < 4; k++) begin
      who = (k < seq.size()) ? seq[k] : -1;
      check("cont_order", 32'(who), 32'(k % 2));
    end

    // single request with a known quotient
    do_reset();
    dnd0 = 32'h40C00000; der0 = 32'h40000000;
    div_delay = 5;
    q_cfg = 32'h40400000;
    begin
      // fixed divider answer rather than the random one op() would pick
      int sc;
      logic saw1;
      req0 = 1'b1; sc = 0; saw1 = 1'b0; nack = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ack1) saw1 = 1'b1;
        if (ack0) begin
          nack++;
          req0 = 1'b0;
          check("single_quo", quo, 32'h40400000);
          check("single_err", 32'(err), 0);
        end
      end
      check("single_ack0_once", 32'(nack), 1);
      check("single_ack1_never", 32'(saw1), 0);
      last_served = 0;
    end

    // stray done while idle
    prev_q = quo; prev_e = err;
    stray_q = 32'hDEADBEEF; stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_quo", quo, prev_q);
    check("stray_err", 32'(prev_e ^ err), 0);
    check("stray_busy", 32'(busy), 0);

    // zero divisor bypass: ack one cycle after the grant edge
    dnd1 = 32'hBF800000; der1 = 32'h00000000;
    op(1'b0, 1'b1, 5, rta, sta);
    check("zero_latency", 32'(rta), 1);

    // timeout: 70 WAIT cycles after ISSUE, then RESP
    dnd0 = 32'h3F800000; der0 = 32'h40400000;
    op(1'b1, 1'b0, 0, rta, sta);
    check("timeout_latency", 32'(sta), 71);

    // reset during WAIT, divider answers three cycles later
    div_delay = 13;
    dnd0 = 32'h41200000; der0 = 32'h40000000;
    req0 = 1'b1;
    for (int i = 0; i < 20 && !div_start; i++) @(negedge clk);
    check("rmw_started", 32'(div_start), 1);
    req0 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmw_busy_now", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    last_served = 1;
    got_ack = 1'b0; got_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0 || ack1) got_ack = 1'b1;
      if (busy) got_busy = 1'b1;
    end
    check("rmw_no_ack", 32'(got_ack), 0);
    check("rmw_no_busy", 32'(got_busy), 0);
    check("rmw_quo", quo, 0);
    check("rmw_err", 32'(err), 0);
    dnd1 = 32'h40000000; der1 = 32'h3F800000;
    op(1'b0, 1'b1, 3, rta, sta);

    // randomized operations
    for (int n = 0; n < 25; n++) begin
      logic r0, r1;
      int dly;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      dnd0 = $urandom; dnd1 = $urandom;
      der0 = ($urandom_range(0, 4) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : $urandom;
      der1 = ($urandom_range(0, 4) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : $urandom;
      if (der0[30:0] == 31'd0 && ($urandom_range(0, 1) == 1)) der0[5] = 1'b1;
      op(r0, r1, dly, rta, sta);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
